mem_dump_ctrl: RTL and testbench

MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

---
 rtl/mem_dump_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_dump_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_ctrl.sv
// Halts-triggered RAM dump engine: takes over the RAM port, reads WORDS words from BASE
// and streams (address, data) records over a valid/ready handshake.
module mem_dump_ctrl #(
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter int unsigned WORDS     = 1024,
  parameter bit          SKIP_ZERO = 1'b0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  output logic        tbCTRL,
  output logic        REN,
  output logic        WEN,
  output logic [31:0] addr,
  output logic [31:0] store,
  input  logic [31:0] load,
  input  logic        ram_ready,
  output logic        dump_valid,
  output logic [31:0] dump_addr,
  output logic [31:0] dump_data,
  input  logic        dump_ready,
  output logic        done,
  output logic        err
);

  localparam int unsigned CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(WORDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_MX = WAIT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    OUT,
    DONE,
    ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       daddr_q, daddr_d;
  logic              advance;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      daddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      daddr_q <= daddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    data_d  = data_q;
    daddr_d = daddr_q;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = REQ;
          addr_d  = BASE;
          cnt_d   = '0;
          wait_d  = '0;
        end
      end
      REQ: begin
        // A completing read beats timeout expiry in the same cycle.
        if (ram_ready) begin
          data_d  = load;
          daddr_d = addr_q;
          wait_d  = '0;
          if (SKIP_ZERO && (load == '0)) advance = 1'b1;
          else                           state_d = OUT;
        end else if (wait_q == WAIT_MX) begin
          state_d = ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      OUT: begin
        if (dump_ready) advance = 1'b1;
      end
      default: ;
    endcase
    // Skipped zero words take the same exit as an accepted record.
    if (advance) begin
      if (cnt_q == LAST) begin
        state_d = DONE;
      end else begin
        state_d = REQ;
        addr_d  = addr_q + 32'd4;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  assign tbCTRL     = (state_q != IDLE);
  assign REN        = (state_q == REQ);
  assign WEN        = 1'b0;
  assign store      = '0;
  assign addr       = addr_q;
  assign dump_valid = (state_q == OUT);
  assign dump_addr  = daddr_q;
  assign dump_data  = data_q;
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERROR);

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Randomized bench for mem_dump_ctrl: three configurations, a RAM/sink model and an
// expected-record queue built directly from the word list.
module tb_mem_dump_ctrl;

  localparam int NI = 3;
  localparam logic [31:0] P_BASE  [NI] = '{32'h0000_0000, 32'hFFFF_FFF8, 32'h0000_0100};
  localparam int          P_WORDS [NI] = '{8, 6, 4};
  localparam bit          P_SKIP  [NI] = '{1'b0, 1'b1, 1'b0};
  localparam int          P_TO    [NI] = '{5, 5, 3};

  logic        clk;
  logic        rst   [NI];
  logic        halt  [NI];
  logic        rdy   [NI];
  logic        rr    [NI];
  logic [31:0] ld    [NI];
  logic        tbc   [NI];
  logic        ren   [NI];
  logic        wen   [NI];
  logic        dv    [NI];
  logic        dn    [NI];
  logic        er    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] store [NI];
  logic [31:0] daddr [NI];
  logic [31:0] ddata [NI];

  mem_dump_ctrl #(.BASE(32'h0000_0000), .WORDS(8), .SKIP_ZERO(1'b0), .TIMEOUT(5)) u0 (
    .CLK(clk), .RST(rst[0]), .halt(halt[0]), .tbCTRL(tbc[0]), .REN(ren[0]), .WEN(wen[0]),
    .addr(addr[0]), .store(store[0]), .load(ld[0]), .ram_ready(rr[0]), .dump_valid(dv[0]),
    .dump_addr(daddr[0]), .dump_data(ddata[0]), .dump_ready(rdy[0]), .done(dn[0]), .err(er[0]));
  mem_dump_ctrl #(.BASE(32'hFFFF_FFF8), .WORDS(6), .SKIP_ZERO(1'b1), .TIMEOUT(5)) u1 (
    .CLK(clk), .RST(rst[1]), .halt(halt[1]), .tbCTRL(tbc[1]), .REN(ren[1]), .WEN(wen[1]),
    .addr(addr[1]), .store(store[1]), .load(ld[1]), .ram_ready(rr[1]), .dump_valid(dv[1]),
    .dump_addr(daddr[1]), .dump_data(ddata[1]), .dump_ready(rdy[1]), .done(dn[1]), .err(er[1]));
  mem_dump_ctrl #(.BASE(32'h0000_0100), .WORDS(4), .SKIP_ZERO(1'b0), .TIMEOUT(3)) u2 (
    .CLK(clk), .RST(rst[2]), .halt(halt[2]), .tbCTRL(tbc[2]), .REN(ren[2]), .WEN(wen[2]),
    .addr(addr[2]), .store(store[2]), .load(ld[2]), .ram_ready(rr[2]), .dump_valid(dv[2]),
    .dump_addr(daddr[2]), .dump_data(ddata[2]), .dump_ready(rdy[2]), .done(dn[2]), .err(er[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [NI][8];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  int          cur = 0;
  int          mode = 0;
  bit          ram_en = 1'b1;
  int          reads = 0;
  int          ren_cyc = 0;
  int          lat = 0;
  int          lat_tgt = 1;
  bit          hold_prev = 1'b0;
  logic [31:0] hold_a, hold_d;

  // RAM, sink and record monitor for the active instance; runs on the falling edge.
  initial forever begin
    int k;
    int off;
    @(negedge clk);
    k = cur;
    if (hold_prev) begin
      chk("hold_valid", dv[k], 1'b1);
      chk("hold_addr", daddr[k], hold_a);
      chk("hold_data", ddata[k], hold_d);
    end
    if (dv[k]) chk("ren_in_out", ren[k], 1'b0);
    if (ren[k] && !rst[k]) ren_cyc++;
    if (rr[k]) begin
      rr[k] = 1'b0;
      lat = 0;
    end else if (ren[k] && ram_en && !rst[k]) begin
      lat++;
      if (lat >= lat_tgt) begin
        chk("read_addr", addr[k], P_BASE[k] + 32'(4 * reads));
        off = int'((addr[k] - P_BASE[k]) >> 2) & 7;
        rr[k] = 1'b1;
        ld[k] = mem[k][off];
        reads++;
        lat = 0;
        lat_tgt = $urandom_range(1, 3);
      end
    end else begin
      lat = 0;
    end
    if (!rr[k]) ld[k] = $urandom;
    case (mode)
      0: rdy[k] = 1'b1;
      1: rdy[k] = ~rdy[k];
      2: rdy[k] = 1'($urandom_range(0, 1));
      default: rdy[k] = 1'b0;
    endcase
    if (dv[k] && rdy[k] && !rst[k]) begin
      chk("rec_expected", 32'(exp_a.size() != 0), 1);
      if (exp_a.size() != 0) begin
        chk("rec_addr", daddr[k], exp_a.pop_front());
        chk("rec_data", ddata[k], exp_d.pop_front());
      end
    end
    hold_prev = dv[k] && !rdy[k] && !rst[k];
    hold_a = daddr[k];
    hold_d = ddata[k];
  end

  task automatic reset_chk(input int k);
    chk("rst_tbctrl", tbc[k], 1'b0);
    chk("rst_ren", ren[k], 1'b0);
    chk("rst_wen", wen[k], 1'b0);
    chk("rst_addr", addr[k], 32'h0);
    chk("rst_store", store[k], 32'h0);
    chk("rst_valid", dv[k], 1'b0);
    chk("rst_daddr", daddr[k], 32'h0);
    chk("rst_ddata", ddata[k], 32'h0);
    chk("rst_done", dn[k], 1'b0);
    chk("rst_err", er[k], 1'b0);
  endtask

  // Pulses reset (possibly mid-dump), rebuilds the expected record list and starts a dump.
  task automatic start_run(input int k, input int m, input bit ram_on);
    exp_a.delete();
    exp_d.delete();
    for (int i = 0; i < P_WORDS[k]; i++)
      if (!(P_SKIP[k] && mem[k][i] == 32'h0)) begin
        exp_a.push_back(P_BASE[k] + 32'(4 * i));
        exp_d.push_back(mem[k][i]);
      end
    @(posedge clk); #1;
    cur = k; mode = m; ram_en = ram_on;
    rst[k] = 1'b1; rr[k] = 1'b0;
    reads = 0; ren_cyc = 0; lat = 0; lat_tgt = 1; hold_prev = 1'b0;
    @(posedge clk); #1;
    reset_chk(k);
    rst[k] = 1'b0; halt[k] = 1'b1;
    @(posedge clk); #1;
    chk("start_ren", ren[k], 1'b1);
    chk("start_addr", addr[k], P_BASE[k]);
  endtask

  task automatic wait_end(input int k);
    int n = 0;
    while (!dn[k] && !er[k] && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    chk("end_reached", 32'(dn[k] | er[k]), 1);
  endtask

  task automatic done_chk(input int k);
    chk("done", dn[k], 1'b1);
    chk("done_err", er[k], 1'b0);
    chk("done_tbctrl", tbc[k], 1'b1);
    chk("done_ren", ren[k], 1'b0);
    chk("done_valid", dv[k], 1'b0);
    chk("done_wen", wen[k], 1'b0);
    chk("done_store", store[k], 32'h0);
    chk("done_left", 32'(exp_a.size()), 0);
    chk("done_reads", 32'(reads), 32'(P_WORDS[k]));
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; halt[k] = 1'b0; rdy[k] = 1'b0; rr[k] = 1'b0; ld[k] = '0;
    end
    // Plain sequence, sink always ready.
    for (int i = 0; i < 8; i++) mem[0][i] = 32'(11 * (i + 1));
    start_run(0, 0, 1'b1);
    wait_end(0);
    done_chk(0);
    repeat (3) @(posedge clk);
    #1 chk("done_absorb", dn[0], 1'b1);
    // Toggling and random sink back-pressure with random words (zeros must still appear).
    for (int m = 1; m <= 2; m++) begin
      for (int i = 0; i < 8; i++) mem[0][i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      start_run(0, m, 1'b1);
      wait_end(0);
      done_chk(0);
    end
    // Reset while a record is waiting, then restart from BASE with halt still high.
    start_run(0, 3, 1'b1);
    begin
      int n = 0;
      while (!dv[0] && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("out_reached", dv[0], 1'b1);
    start_run(0, 2, 1'b1);
    wait_end(0);
    done_chk(0);
    // Zero skipping across the 32-bit address wrap; halt dropped mid-dump.
    mem[1][0] = 32'd5; mem[1][1] = 32'd0; mem[1][2] = 32'd0;
    mem[1][3] = 32'd7; mem[1][4] = 32'd0; mem[1][5] = 32'd9;
    start_run(1, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1 halt[1] = 1'b0;
    wait_end(1);
    done_chk(1);
    for (int i = 0; i < 6; i++) mem[1][i] = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
    start_run(1, 2, 1'b1);
    wait_end(1);
    done_chk(1);
    // RAM never answers: abort after TIMEOUT+1 request cycles.
    for (int i = 0; i < 4; i++) mem[2][i] = $urandom;
    start_run(2, 0, 1'b0);
    wait_end(2);
    chk("to_err", er[2], 1'b1);
    chk("to_done", dn[2], 1'b0);
    chk("to_ren", ren[2], 1'b0);
    chk("to_tbctrl", tbc[2], 1'b1);
    chk("to_valid", dv[2], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("to_absorb", er[2], 1'b1);
    chk("to_ren_cycles", 32'(ren_cyc), 32'(P_TO[2] + 1));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
